// File: rtl/third_loop_fsm.sv
// RC4 keystream (PRGA) sequencer: walks the S-box RAM, decrypts MSG_LEN message
// bytes into the output RAM and flags runs whose plaintext is not lowercase/space.
module third_loop_fsm #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_L3,
    input  logic [7:0] q_loop3,
    input  logic [7:0] message_data,
    input  logic [7:0] out_q,
    output logic [7:0] address_loop3,
    output logic [7:0] data_loop3,
    output logic       wren_loop3,
    output logic [7:0] message_address,
    output logic [7:0] out_address,
    output logic [7:0] out_data,
    output logic       out_wren,
    output logic       finish_L3,
    output logic       run_again
);

    typedef enum logic [11:0] {
        IDLE      = 12'd0,
        INIT      = 12'd1,
        INC_I     = 12'd2,
        WAIT_SI   = 12'd3,
        READ_SI   = 12'd4,
        CALC_J    = 12'd5,
        WAIT_SJ   = 12'd6,
        READ_SJ   = 12'd7,
        WRITE_I   = 12'd8,
        WRITE_J   = 12'd9,
        ADDR_F    = 12'd10,
        WAIT_F    = 12'd11,
        READ_F    = 12'd12,
        WRITE_OUT = 12'd13,
        NEXT      = 12'd14,
        DONE      = 12'd15
    } state_t;

    localparam logic [8:0] LEN9 = 9'(MSG_LEN);

    state_t     state, state_next;
    logic [7:0] i_reg, i_next, j_reg, j_next, k_reg, k_next;
    logic [7:0] si_reg, si_next, sj_reg, sj_next, f_reg, f_next, msg_reg, msg_next;
    logic [7:0] addr_next, data_next, maddr_next, oaddr_next, odata_next;
    logic       wren_next, owren_next, finish_next, again_next;
    logic       last_byte;

    // The output-RAM read port is reserved; fold it so it is visibly consumed.
    logic unused_out_q;
    assign unused_out_q = ^out_q;

    // 9-bit compare so MSG_LEN = 256 terminates after k wraps from 255.
    assign last_byte = (({1'b0, k_reg} + 9'd1) == LEN9);

    // Write strobes and the output byte are set up on entry to their state so
    // they are asserted exactly while the FSM sits in WRITE_I/WRITE_J/WRITE_OUT/DONE.
    always_comb begin
        state_next  = state;
        i_next      = i_reg;
        j_next      = j_reg;
        k_next      = k_reg;
        si_next     = si_reg;
        sj_next     = sj_reg;
        f_next      = f_reg;
        msg_next    = msg_reg;
        addr_next   = address_loop3;
        data_next   = data_loop3;
        wren_next   = 1'b0;
        maddr_next  = message_address;
        oaddr_next  = out_address;
        odata_next  = out_data;
        owren_next  = 1'b0;
        finish_next = 1'b0;
        again_next  = run_again;
        case (state)
            IDLE: if (start_L3) state_next = INIT;
            INIT: begin
                i_next     = 8'd0;
                j_next     = 8'd0;
                k_next     = 8'd0;
                maddr_next = 8'd0;
                again_next = 1'b0;
                state_next = INC_I;
            end
            INC_I: begin
                i_next     = i_reg + 8'd1;
                addr_next  = i_reg + 8'd1;
                state_next = WAIT_SI;
            end
            WAIT_SI: state_next = READ_SI;
            READ_SI: begin
                si_next    = q_loop3;
                state_next = CALC_J;
            end
            CALC_J: begin
                j_next     = j_reg + si_reg;
                addr_next  = j_reg + si_reg;
                state_next = WAIT_SJ;
            end
            WAIT_SJ: state_next = READ_SJ;
            READ_SJ: begin
                sj_next    = q_loop3;
                addr_next  = i_reg;
                data_next  = q_loop3;
                wren_next  = 1'b1;
                state_next = WRITE_I;
            end
            WRITE_I: begin
                addr_next  = j_reg;
                data_next  = si_reg;
                wren_next  = 1'b1;
                state_next = WRITE_J;
            end
            WRITE_J: state_next = ADDR_F;
            ADDR_F: begin
                addr_next  = si_reg + sj_reg;
                state_next = WAIT_F;
            end
            WAIT_F: state_next = READ_F;
            READ_F: begin
                f_next     = q_loop3;
                msg_next   = message_data;
                oaddr_next = k_reg;
                odata_next = q_loop3 ^ message_data;
                owren_next = 1'b1;
                state_next = WRITE_OUT;
            end
            WRITE_OUT: begin
                if (!(out_data == 8'h20 || (out_data >= 8'h61 && out_data <= 8'h7a)))
                    again_next = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                k_next     = k_reg + 8'd1;
                maddr_next = k_reg + 8'd1;
                if (last_byte) begin
                    finish_next = 1'b1;
                    state_next  = DONE;
                end else begin
                    state_next  = INC_I;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state           <= IDLE;
            i_reg           <= 8'd0;
            j_reg           <= 8'd0;
            k_reg           <= 8'd0;
            si_reg          <= 8'd0;
            sj_reg          <= 8'd0;
            f_reg           <= 8'd0;
            msg_reg         <= 8'd0;
            address_loop3   <= 8'd0;
            data_loop3      <= 8'd0;
            wren_loop3      <= 1'b0;
            message_address <= 8'd0;
            out_address     <= 8'd0;
            out_data        <= 8'd0;
            out_wren        <= 1'b0;
            finish_L3       <= 1'b0;
            run_again       <= 1'b0;
        end else begin
            state           <= state_next;
            i_reg           <= i_next;
            j_reg           <= j_next;
            k_reg           <= k_next;
            si_reg          <= si_next;
            sj_reg          <= sj_next;
            f_reg           <= f_next;
            msg_reg         <= msg_next;
            address_loop3   <= addr_next;
            data_loop3      <= data_next;
            wren_loop3      <= wren_next;
            message_address <= maddr_next;
            out_address     <= oaddr_next;
            out_data        <= odata_next;
            out_wren        <= owren_next;
            finish_L3       <= finish_next;
            run_again       <= again_next;
        end
    end

endmodule

// File: tb/tb_third_loop_fsm.sv
// Scoreboard bench for third_loop_fsm: an RC4 reference model queues the expected
// output-RAM writes, and a monitor pops and compares them as the DUT writes.
module tb_third_loop_fsm;

    localparam int L = 32;

    logic       clk = 1'b0;
    logic       reset_n, start_L3, load_req;
    logic [7:0] q_loop3, message_data, out_q;
    logic [7:0] address_loop3, data_loop3, message_address, out_address, out_data;
    logic       wren_loop3, out_wren, finish_L3, run_again;

    always #5 clk = ~clk;

    third_loop_fsm #(.MSG_LEN(L)) dut (
        .clk(clk), .reset_n(reset_n), .start_L3(start_L3),
        .q_loop3(q_loop3), .message_data(message_data), .out_q(out_q),
        .address_loop3(address_loop3), .data_loop3(data_loop3), .wren_loop3(wren_loop3),
        .message_address(message_address), .out_address(out_address),
        .out_data(out_data), .out_wren(out_wren),
        .finish_L3(finish_L3), .run_again(run_again)
    );

    // Synchronous-read S-RAM and message ROM; the S-RAM is preloaded on load_req.
    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] msg_mem [256];
    always @(posedge clk) begin
        if (load_req) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
        end else if (wren_loop3) begin
            s_mem[address_loop3] <= data_loop3;
        end
        q_loop3      <= s_mem[address_loop3];
        message_data <= msg_mem[message_address];
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0, n_err = 0, finish_cnt = 0, wr_cnt = 0;
    bit exp_again = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_text(input int c);
        return (c == 32) || (c >= 97 && c <= 122);
    endfunction

    always @(posedge clk) begin
        wr_t e;
        #1;
        if (out_wren) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0d data=%02h expected addr=%0d data=%02h",
                         out_address, out_data, e.addr, e.data);
                chk($sformatf("out_address[%0d]", e.addr), out_address, e.addr);
                chk($sformatf("out_data[%0d]", e.addr), out_data, e.data);
            end
        end
        if (finish_L3) begin
            finish_cnt++;
            chk("run_again_at_finish", run_again, exp_again);
        end
    end

    // s_kind: 0 identity S, 1 random permutation.
    // pt_kind: 0 msg=0x41+k, 1 plaintext all 0x61, 2 random msg,
    //          3 random valid text, 4 valid text with one boundary-invalid byte.
    task automatic run_case(input int s_kind, input int pt_kind, input bit poke, input int abort_k);
        int sm [256];
        int ks [L];
        int msg, pt, i, j, t, r, cyc, fc0, bad_pos, outv;
        wr_t w;
        for (int n = 0; n < 256; n++) sm[n] = n;
        if (s_kind != 0)
            for (int n = 255; n > 0; n--) begin
                r = $urandom_range(n, 0);
                t = sm[n]; sm[n] = sm[r]; sm[r] = t;
            end
        for (int n = 0; n < 256; n++) s_init[n] = 8'(sm[n]);
        i = 0; j = 0;
        for (int k = 0; k < L; k++) begin
            i = (i + 1) % 256;
            j = (j + sm[i]) % 256;
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
            ks[k] = sm[(sm[i] + sm[j]) % 256];
        end
        bad_pos = $urandom_range(L - 1, 0);
        exp_again = 1'b0;
        exp_q.delete();
        for (int k = 0; k < L; k++) begin
            r = $urandom_range(3, 0);
            pt = (r == 0) ? 32'h20 : (r == 1) ? 32'h61 : (r == 2) ? 32'h7a : $urandom_range(32'h7a, 32'h61);
            if (pt_kind == 4 && k == bad_pos)
                pt = (r == 0) ? 32'h1f : (r == 1) ? 32'h21 : (r == 2) ? 32'h60 : 32'h7b;
            case (pt_kind)
                0:       msg = (32'h41 + k) % 256;
                1:       msg = ks[k] ^ 32'h61;
                2:       msg = $urandom_range(255, 0);
                default: msg = ks[k] ^ pt;
            endcase
            msg_mem[k] = 8'(msg);
            outv = ks[k] ^ msg;
            w.addr = 8'(k);
            w.data = 8'(outv);
            exp_q.push_back(w);
            if (!is_text(outv)) exp_again = 1'b1;
        end
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        wr_cnt = 0;
        fc0 = finish_cnt;
        start_L3 = 1'b1;
        @(negedge clk); start_L3 = 1'b0;
        cyc = 1;
        while (finish_cnt == fc0 && cyc < 13 * L + 20) begin
            if (abort_k >= 0 && cyc > 2 && message_address == 8'(abort_k)) begin
                reset_n = 1'b1;
                #1;
                exp_q.delete();
                chk("abort_sram_outputs", {address_loop3, data_loop3, wren_loop3}, 0);
                chk("abort_out_outputs", {message_address, out_address, out_data, out_wren}, 0);
                chk("abort_flags", {finish_L3, run_again}, 0);
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    chk("abort_no_writes", {wren_loop3, out_wren}, 0);
                end
                chk("abort_writes_before_reset", wr_cnt, abort_k);
                reset_n = 1'b0;
                @(negedge clk);
                return;
            end
            start_L3 = poke && (cyc == 40 || cyc == 200);
            @(negedge clk);
            cyc++;
        end
        start_L3 = 1'b0;
        if (finish_cnt == fc0) begin
            chk("finish_timeout", 0, 1);
        end else begin
            chk("latency_within_bound", int'(cyc <= 13 * L + 4), 1);
        end
        repeat (30) @(negedge clk);
        chk("finish_pulse_count", finish_cnt - fc0, 1);
        chk("write_count", wr_cnt, L);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("run s_kind=%0d pt_kind=%0d poke=%0d done in %0d cycles, run_again=%0d",
                 s_kind, pt_kind, poke, cyc, run_again);
    endtask

    initial begin
        reset_n  = 1'b1;
        start_L3 = 1'b0;
        load_req = 1'b0;
        out_q    = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_sram_outputs", {address_loop3, data_loop3, wren_loop3}, 0);
        chk("reset_out_outputs", {message_address, out_address, out_data, out_wren}, 0);
        chk("reset_flags", {finish_L3, run_again}, 0);
        reset_n = 1'b0;
        @(negedge clk);
        run_case(0, 0, 1'b0, -1);
        run_case(1, 1, 1'b0, -1);
        run_case(1, 2, 1'b1, -1);
        run_case(1, 3, 1'b0, -1);
        run_case(1, 4, 1'b0, -1);
        run_case(0, 0, 1'b0, 10);
        run_case(0, 0, 1'b0, -1);
        run_case(1, 2, 1'b1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
